// File: rtl/mad_accumulator.sv
// Accumulates a programmed number of signed 32-bit partial dot products onto an
// initial value and returns the tagged sum on the CV-X-IF result handshake.
module mad_accumulator #(
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned ID_W     = 3,
   parameter bit          SATURATE = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_valid_i,
   output logic             start_ready_o,
   input  logic [LEN_W-1:0] len_i,
   input  logic [31:0]      init_i,
   input  logic [ID_W-1:0]  id_i,
   input  logic [4:0]       rd_i,
   input  logic             psum_valid_i,
   input  logic [31:0]      psum_i,
   input  logic             kill_i,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic [31:0]      result_data_o,
   output logic [ID_W-1:0]  result_id_o,
   output logic [4:0]       result_rd_o,
   output logic             result_ovf_o,
   output logic             busy_o,
   output logic             drop_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      acc;
   logic [LEN_W-1:0] cnt;
   logic [ID_W-1:0]  id;
   logic [4:0]       rd;
   logic             ovf;
   logic             drop;

   logic             start_fire;
   logic             psum_fire;
   logic [32:0]      sum;
   logic             sum_ovf;
   logic [31:0]      sum_res;

   // kill blocks both a new start and a partial arriving in the same cycle
   assign start_fire = (state == IDLE)  & start_valid_i & ~kill_i;
   assign psum_fire  = (state == ACCUM) & psum_valid_i  & ~kill_i;

   // 33-bit sign-extended add; overflow when the two top bits disagree
   assign sum     = {acc[31], acc} + {psum_i[31], psum_i};
   assign sum_ovf = sum[32] ^ sum[31];

   always_comb begin
      sum_res = sum[31:0];
      if (SATURATE && sum_ovf)
         sum_res = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_fire)
               state_nxt = (len_i == '0) ? DONE : ACCUM;
         end
         ACCUM: begin
            if (kill_i)
               state_nxt = IDLE;
            else if (psum_valid_i && cnt == LEN_W'(1))
               state_nxt = DONE;
         end
         DONE: begin
            if (kill_i || result_ready_i)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc  <= '0;
         cnt  <= '0;
         id   <= '0;
         rd   <= '0;
         ovf  <= 1'b0;
         drop <= 1'b0;
      end else begin
         drop <= psum_valid_i & (state != ACCUM);
         if (start_fire) begin
            acc <= init_i;
            cnt <= len_i;
            id  <= id_i;
            rd  <= rd_i;
            ovf <= 1'b0;
         end else if (psum_fire) begin
            acc <= sum_res;
            cnt <= cnt - LEN_W'(1);
            ovf <= ovf | sum_ovf;
         end
      end
   end

   assign start_ready_o  = (state == IDLE);
   assign busy_o         = (state != IDLE);
   assign result_valid_o = (state == DONE);
   assign result_data_o  = acc;
   assign result_id_o    = id;
   assign result_rd_o    = rd;
   assign result_ovf_o   = ovf;
   assign drop_o         = drop;

endmodule

// File: tb/tb_mad_accumulator.sv
// Directed bench for mad_accumulator: a saturating and a wrapping instance share
// stimulus and are checked every cycle against an arithmetic model.
module tb_mad_accumulator;

   localparam int LEN_W = 8;
   localparam int ID_W  = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_valid = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic [31:0]      init = '0;
   logic [ID_W-1:0]  id = '0;
   logic [4:0]       rd = '0;
   logic             psum_valid = 1'b0;
   logic [31:0]      psum = '0;
   logic             kill = 1'b0;
   logic             result_ready = 1'b0;

   logic             s_start_ready, s_valid, s_ovf, s_busy, s_drop;
   logic [31:0]      s_data;
   logic [ID_W-1:0]  s_id;
   logic [4:0]       s_rd;
   logic             w_start_ready, w_valid, w_ovf, w_busy, w_drop;
   logic [31:0]      w_data;
   logic [ID_W-1:0]  w_id;
   logic [4:0]       w_rd;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mad_accumulator #(.LEN_W(LEN_W), .ID_W(ID_W), .SATURATE(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_valid_i(start_valid), .start_ready_o(s_start_ready),
      .len_i(len), .init_i(init), .id_i(id), .rd_i(rd), .psum_valid_i(psum_valid), .psum_i(psum),
      .kill_i(kill), .result_valid_o(s_valid), .result_ready_i(result_ready),
      .result_data_o(s_data), .result_id_o(s_id), .result_rd_o(s_rd), .result_ovf_o(s_ovf),
      .busy_o(s_busy), .drop_o(s_drop));

   mad_accumulator #(.LEN_W(LEN_W), .ID_W(ID_W), .SATURATE(1'b0)) dut_w (
      .clk_i(clk), .rst_ni(rst_n), .start_valid_i(start_valid), .start_ready_o(w_start_ready),
      .len_i(len), .init_i(init), .id_i(id), .rd_i(rd), .psum_valid_i(psum_valid), .psum_i(psum),
      .kill_i(kill), .result_valid_o(w_valid), .result_ready_i(result_ready),
      .result_data_o(w_data), .result_id_o(w_id), .result_rd_o(w_rd), .result_ovf_o(w_ovf),
      .busy_o(w_busy), .drop_o(w_drop));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: plain integer add, then clamp or truncate to 32 bits.
   function automatic logic [31:0] add_m(input logic [31:0] a, input logic [31:0] b,
                                         input bit sat, output bit ov);
      longint s;
      s  = longint'($signed(a)) + longint'($signed(b));
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      if (ov && sat) return (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return s[31:0];
   endfunction

   // phase: 0 waiting for a start, 1 collecting partials, 2 holding result
   int               m_phase = 0;
   int               m_left = 0;
   bit               m_armed = 1'b0;
   bit               m_drop = 1'b0;
   logic [31:0]      m_sum_s = '0, m_sum_w = '0;
   bit               m_ovf_s = 1'b0, m_ovf_w = 1'b0;
   logic [ID_W-1:0]  m_id = '0;
   logic [4:0]       m_rd = '0;

   always @(posedge clk) begin
      bit ov;
      if (!rst_n) begin
         m_armed = 1'b1;
         m_phase = 0; m_left = 0; m_drop = 1'b0;
         m_sum_s = '0; m_sum_w = '0; m_ovf_s = 1'b0; m_ovf_w = 1'b0;
         m_id = '0; m_rd = '0;
      end else begin
         m_drop = psum_valid && (m_phase != 1);
         case (m_phase)
            0: if (start_valid && !kill) begin
               m_sum_s = init; m_sum_w = init; m_ovf_s = 1'b0; m_ovf_w = 1'b0;
               m_id = id; m_rd = rd; m_left = int'(len);
               m_phase = (len == 0) ? 2 : 1;
            end
            1: if (kill) m_phase = 0;
               else if (psum_valid) begin
                  m_sum_s = add_m(m_sum_s, psum, 1'b1, ov); m_ovf_s = m_ovf_s | ov;
                  m_sum_w = add_m(m_sum_w, psum, 1'b0, ov); m_ovf_w = m_ovf_w | ov;
                  m_left--;
                  if (m_left == 0) m_phase = 2;
               end
            default: if (kill || result_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_armed) begin
         chk("s_valid", 64'(s_valid), 64'(m_phase == 2));
         chk("w_valid", 64'(w_valid), 64'(m_phase == 2));
         chk("s_busy", 64'(s_busy), 64'(m_phase != 0));
         chk("s_ready", 64'(s_start_ready), 64'(m_phase == 0));
         chk("s_drop", 64'(s_drop), 64'(m_drop));
         chk("w_drop", 64'(w_drop), 64'(m_drop));
         if (m_phase == 2) begin
            chk("s_data", 64'(s_data), 64'(m_sum_s));
            chk("w_data", 64'(w_data), 64'(m_sum_w));
            chk("s_ovf", 64'(s_ovf), 64'(m_ovf_s));
            chk("w_ovf", 64'(w_ovf), 64'(m_ovf_w));
            chk("s_id", 64'(s_id), 64'(m_id));
            chk("s_rd", 64'(s_rd), 64'(m_rd));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int l, input logic [31:0] iv, input int i, input int r);
      start_valid = 1'b1; len = LEN_W'(l); init = iv; id = ID_W'(i); rd = 5'(r);
      tick();
      start_valid = 1'b0;
   endtask

   task automatic feed(input logic [31:0] p);
      psum_valid = 1'b1; psum = p;
      tick();
      psum_valid = 1'b0;
   endtask

   task automatic accept();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk("valid_drop_after_ready", 64'(s_valid), 64'd0);
   endtask

   initial begin
      tick(); tick();
      chk("rst_ready", 64'(s_start_ready), 64'd1);
      chk("rst_valid", 64'(s_valid), 64'd0);
      chk("rst_data", 64'(s_data), 64'd0);
      chk("rst_busy", 64'(s_busy), 64'd0);
      rst_n = 1'b1;
      tick();

      // basic sum: 10 + 100 - 20 + 5
      start(3, 32'd10, 2, 7);
      feed(32'd100); feed(-32'sd20); feed(32'd5);
      chk("basic_valid", 64'(s_valid), 64'd1);
      chk("basic_data", 64'(s_data), 64'd95);
      chk("basic_id", 64'(s_id), 64'd2);
      chk("basic_rd", 64'(s_rd), 64'd7);
      chk("basic_ovf", 64'(s_ovf), 64'd0);
      accept();

      // zero length with backpressure and a stray partial while holding
      start(0, 32'hDEAD_BEEF, 1, 9);
      for (int i = 0; i < 4; i++) begin
         chk("zl_valid", 64'(s_valid), 64'd1);
         chk("zl_data", 64'(s_data), 64'hDEAD_BEEF);
         psum_valid = (i == 0); psum = 32'd5;
         tick();
         psum_valid = 1'b0;
      end
      chk("zl_still_valid", 64'(s_valid), 64'd1);
      accept();

      // overflow: saturating instance clamps, wrapping instance truncates
      start(2, 32'h7FFF_FFF0, 3, 4);
      feed(32'h20); feed(-32'sh10);
      chk("sat_data", 64'(s_data), 64'h7FFF_FFEF);
      chk("sat_ovf", 64'(s_ovf), 64'd1);
      chk("wrap_data", 64'(w_data), 64'h8000_0000);
      chk("wrap_ovf", 64'(w_ovf), 64'd1);
      accept();

      // stray partial in IDLE, then a start ignored during ACCUM
      feed(32'd77);
      chk("drop_pulse", 64'(s_drop), 64'd1);
      tick();
      chk("drop_clear", 64'(s_drop), 64'd0);
      start(2, 32'd1, 5, 3);
      start_valid = 1'b1; len = '0; init = 32'd99; id = 3'd1; rd = 5'd1;
      feed(32'd2);
      start_valid = 1'b0;
      feed(32'd3);
      chk("ign_data", 64'(s_data), 64'd6);
      chk("ign_id", 64'(s_id), 64'd5);
      chk("ign_rd", 64'(s_rd), 64'd3);
      accept();

      // kill after one partial; a partial in the kill cycle is discarded
      start(3, 32'd0, 2, 2);
      feed(32'd7);
      kill = 1'b1; psum_valid = 1'b1; psum = 32'd1000;
      tick();
      kill = 1'b0; psum_valid = 1'b0;
      chk("kill_busy", 64'(s_busy), 64'd0);
      chk("kill_valid", 64'(s_valid), 64'd0);
      tick(); tick();
      chk("kill_no_result", 64'(s_valid), 64'd0);

      // synchronous reset mid-operation
      start(3, 32'd0, 1, 1);
      feed(32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_mid_busy", 64'(s_busy), 64'd0);
      chk("rst_mid_valid", 64'(s_valid), 64'd0);
      chk("rst_mid_data", 64'(s_data), 64'd0);

      start(1, 32'd0, 6, 12);
      feed(32'd4);
      chk("fresh_valid", 64'(s_valid), 64'd1);
      chk("fresh_data", 64'(s_data), 64'd4);
      chk("fresh_rd", 64'(s_rd), 64'd12);
      accept();

      // kill while holding a result discards it
      start(0, 32'd55, 0, 0);
      kill = 1'b1;
      tick();
      kill = 1'b0;
      chk("kill_done_valid", 64'(s_valid), 64'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mad_accumulator.md
Name: mad_accumulator

Overview:
- Downstream stage of the CV-X-IF byte dot-product (MAD) unit.
- Consumes the 32-bit partial dot products the MAD unit emits, one per result_valid pulse, and accumulates a programmed number of them onto an initial value.
- Returns the final sum, tagged with instruction id and destination register, to the CV-X-IF result path over a valid/ready handshake.

Parameters:
- LEN_W, 8, width of the partial-count field; up to 2^LEN_W-1 partials per operation.
- ID_W, 3, width of the CV-X-IF instruction id tag.
- SATURATE, 1, 1 = clamp signed overflow, 0 = two's-complement wrap.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  synchronous active-low reset.
- start_valid_i  input  1  new accumulate operation request.
- start_ready_o  output  1  request accepted this cycle when both high; equals (state==IDLE).
- len_i  input  LEN_W  number of partials to accumulate.
- init_i  input  32  signed initial accumulator value.
- id_i  input  ID_W  instruction id captured at start.
- rd_i  input  5  destination register captured at start.
- psum_valid_i  input  1  partial-sum strobe from the MAD unit.
- psum_i  input  32  signed partial sum.
- kill_i  input  1  abort the current operation.
- result_valid_o  output  1  final result available.
- result_ready_i  input  1  consumer accepts the result.
- result_data_o  output  32  accumulated sum.
- result_id_o  output  ID_W  captured id.
- result_rd_o  output  5  captured rd.
- result_ovf_o  output  1  sticky: at least one addition overflowed.
- busy_o  output  1  state != IDLE.
- drop_o  output  1  one-cycle pulse: psum_valid_i arrived while not in ACCUM.

Behaviour:
- Reset, synchronous, rst_ni low at a clock edge:
  - State goes to IDLE.
  - All outputs go to 0, except start_ready_o, which is 1 (IDLE).
  - Accumulator, counter and captured tags are cleared.
  - Reset overrides every other input, mid-operation included.
- State machine:
  - IDLE:
    - On start_valid_i: capture id_i, rd_i, len_i, and load acc=init_i; clear ovf.
    - If len_i==0, go to DONE (result = init_i); otherwise go to ACCUM with cnt=len_i.
  - ACCUM:
    - Each cycle with psum_valid_i: acc <= acc + psum_i (rules below); cnt decrements.
    - When the accepted partial has cnt==1, go to DONE.
    - Partials accepted back-to-back every cycle; gaps allowed.
  - DONE:
    - result_valid_o=1, with data/id/rd/ovf held stable until result_ready_i.
    - On result_ready_i, go to IDLE; result_valid_o drops the next cycle.
- Latency: result_valid_o rises the cycle after the final partial is accepted. For len=0, it rises the cycle after start.
- Arithmetic:
  - 33-bit signed sum of acc and psum_i.
  - Overflow when the result does not fit in 32 signed bits; sets the sticky ovf.
  - SATURATE=1: clamp to 0x7FFFFFFF (positive overflow) or 0x80000000 (negative overflow).
  - SATURATE=0: keep the low 32 bits.
  - Once saturated, later additions continue from the clamped value.
- Boundary rules:
  - start_valid_i outside IDLE is ignored; start_ready_o=0, no state change.
  - Back-to-back operations are not overlapped: start is only accepted after DONE→IDLE.
  - psum_valid_i in IDLE or DONE: the partial is discarded and drop_o pulses for one cycle; acc is unchanged.
  - kill_i in ACCUM or DONE: go to IDLE next cycle; no result; result_valid_o deasserts next cycle.
  - kill_i in IDLE with start_valid_i: start is not accepted.
  - kill_i has priority over psum_valid_i and result_ready_i in the same cycle.
  - result_ready_i outside DONE has no effect.
  - Counter wrap cannot occur: the transition out of ACCUM is at cnt==1.

Test Plan:
- Basic sum: start len=3, init=10, id=2, rd=7; psums 100, -20, 5 on consecutive cycles.
  -> result_valid_o the cycle after the third partial; data=95, id=2, rd=7, ovf=0.
- Zero length and backpressure: len=0, init=0xDEADBEEF; result_ready_i held low for 4 cycles.
  -> result_valid_o asserted from cycle 1 onward; data stable 0xDEADBEEF throughout; clears one cycle after ready.
- Saturation, SATURATE=1: init=0x7FFFFFF0, len=2, psums 0x20 then -0x10.
  -> data=0x7FFFFFEF, ovf=1.
- Wrap, SATURATE=0: same stimulus as the saturation case.
  -> data=0x80000000, ovf=1.
- Stray partials and ignored start: psum_valid_i in IDLE, and start_valid_i while in ACCUM.
  -> drop_o pulses once; the second start is ignored and the in-flight operation's result is unaffected.
- Kill and reset mid-operation: kill_i after 1 of 3 partials; then rst_ni low for 1 cycle during ACCUM.
  -> no result_valid_o in either case; busy_o=0 next cycle; a fresh start (len=1, psum=4, init=0) returns 4.
